// File: rtl/n_term_tile_cfg.sv
// North-edge terminal tile: loops north-travelling bundles back south with per-bundle
// direct/registered/constant/zero drive and index rotation, plus sticky activity flags.
module n_term_tile_cfg #(
  parameter int unsigned N1_W            = 4,
  parameter int unsigned N2_W            = 8,
  parameter int unsigned N4_W            = 16,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 20
) (
  input  logic                       UserCLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  input  logic [N1_W-1:0]            N1END,
  input  logic [N2_W-1:0]            N2MID,
  input  logic [N2_W-1:0]            N2END,
  input  logic [N4_W-1:0]            N4END,
  input  logic                       Ci,
  output logic [N1_W-1:0]            S1BEG,
  output logic [N2_W-1:0]            S2BEG,
  output logic [N2_W-1:0]            S2BEGb,
  output logic [N4_W-1:0]            S4BEG,
  output logic [4:0]                 ActivityFlags
);

  localparam int unsigned NB = 4;
  localparam int unsigned BW [NB] = '{N1_W, N2_W, N2_W, N4_W};

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_REG    = 2'd1,
    MODE_CONST  = 2'd2,
    MODE_ZERO   = 2'd3
  } mode_e;

  logic [11:0]          cfg0_q, cfg0_d;
  logic [19:0]          cfg1_q, cfg1_d;
  logic [NB-1:0][31:0]  src, rot_src, pipe_q, bout, samp_q;
  logic                 ci_samp_q, primed_q;
  logic [4:0]           act_q, act_d, act_set, act_clr;

  // out[i] = src[(i + r) mod w]; true modulo so non-power-of-two widths work
  function automatic logic [31:0] rotate(input logic [31:0] v, input int unsigned w,
                                         input logic [4:0] rot);
    logic [31:0] res;
    logic [4:0]  idx;
    int unsigned r;
    res = '0;
    r   = 32'(rot) % w;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) begin
        idx         = 5'((i + r) % w);
        res[i[4:0]] = v[idx];
      end
    end
    return res;
  endfunction

  assign src[0] = 32'(N1END);
  assign src[1] = 32'(N2MID);
  assign src[2] = 32'(N2END);
  assign src[3] = 32'(N4END);

  for (genvar b = 0; b < NB; b++) begin : g_bundle
    mode_e      mode;
    logic [4:0] rot;
    assign mode       = mode_e'(cfg0_q[2*b +: 2]);
    assign rot        = cfg1_q[5*b +: 5];
    assign rot_src[b] = rotate(src[b], BW[b], rot);
    assign bout[b]    = (mode == MODE_DIRECT) ? rot_src[b] :
                        (mode == MODE_REG)    ? pipe_q[b]  :
                        (mode == MODE_CONST)  ? {32{cfg0_q[8+b]}} : '0;
    assign act_set[b] = |(src[b] ^ samp_q[b]);
  end

  assign act_set[4] = Ci ^ ci_samp_q;

  // Frame 2 is a clear command, not storage; a same-edge toggle overrides the clear
  assign act_clr = FrameStrobe[2] ? FrameData[4:0] : '0;
  assign act_d   = (act_q & ~act_clr) | (primed_q ? act_set : '0);
  assign cfg0_d  = FrameStrobe[0] ? FrameData[11:0] : cfg0_q;
  assign cfg1_d  = FrameStrobe[1] ? FrameData[19:0] : cfg1_q;

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      cfg0_q    <= '0;
      cfg1_q    <= '0;
      pipe_q    <= '0;
      samp_q    <= '0;
      ci_samp_q <= 1'b0;
      primed_q  <= 1'b0;
      act_q     <= '0;
    end else begin
      cfg0_q    <= cfg0_d;
      cfg1_q    <= cfg1_d;
      pipe_q    <= rot_src;
      samp_q    <= src;
      ci_samp_q <= Ci;
      primed_q  <= 1'b1;
      act_q     <= act_d;
    end
  end

  assign S1BEG         = bout[0][N1_W-1:0];
  assign S2BEG         = bout[1][N2_W-1:0];
  assign S2BEGb        = bout[2][N2_W-1:0];
  assign S4BEG         = bout[3][N4_W-1:0];
  assign ActivityFlags = act_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, FrameData, FrameStrobe, bout};

endmodule

// File: tb/tb_n_term_tile_cfg.sv
// Randomized bench for n_term_tile_cfg, checked against a shift-based behavioural model.
module tb_n_term_tile_cfg;

  localparam int N1_W = 4;
  localparam int N2_W = 8;
  localparam int N4_W = 16;
  localparam int FB   = 32;
  localparam int MF   = 20;

  logic            UserCLK = 1'b0;
  logic            resetn;
  logic [FB-1:0]   FrameData;
  logic [MF-1:0]   FrameStrobe;
  logic [N1_W-1:0] N1END;
  logic [N2_W-1:0] N2MID, N2END;
  logic [N4_W-1:0] N4END;
  logic            Ci;
  logic [N1_W-1:0] S1BEG;
  logic [N2_W-1:0] S2BEG, S2BEGb;
  logic [N4_W-1:0] S4BEG;
  logic [4:0]      ActivityFlags;

  int n_checks = 0;
  int n_pass   = 0;

  n_term_tile_cfg #(
    .N1_W(N1_W), .N2_W(N2_W), .N4_W(N4_W),
    .FrameBitsPerRow(FB), .MaxFramesPerCol(MF)
  ) dut (
    .UserCLK(UserCLK), .resetn(resetn), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
    .N1END(N1END), .N2MID(N2MID), .N2END(N2END), .N4END(N4END), .Ci(Ci),
    .S1BEG(S1BEG), .S2BEG(S2BEG), .S2BEGb(S2BEGb), .S4BEG(S4BEG),
    .ActivityFlags(ActivityFlags)
  );

  always #5 UserCLK = ~UserCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model state
  logic [31:0] m_cfg0, m_cfg1;
  logic [31:0] m_pipe [4];
  logic [31:0] m_samp [5];
  bit          m_primed;
  logic [4:0]  m_flags;
  int          bw [4] = '{N1_W, N2_W, N2_W, N4_W};

  function automatic logic [31:0] wmask(int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] src_now(int k);
    case (k)
      0:       return 32'(N1END);
      1:       return 32'(N2MID);
      2:       return 32'(N2END);
      3:       return 32'(N4END);
      default: return 32'(Ci);
    endcase
  endfunction

  // out[i] = v[(i+r) mod w] is a right-rotate by r within w bits
  function automatic logic [31:0] rot_ref(logic [31:0] v, int w, int field);
    int          r;
    logic [63:0] x;
    r = field % w;
    x = 64'(v & wmask(w));
    x = (x >> r) | (x << (w - r));
    return 32'(x) & wmask(w);
  endfunction

  function automatic int rot_field(int b);
    return int'((m_cfg1 >> (5 * b)) & 32'd31);
  endfunction

  function automatic logic [31:0] exp_out(int b);
    case ((m_cfg0 >> (2 * b)) & 32'd3)
      32'd0:   return rot_ref(src_now(b), bw[b], rot_field(b));
      32'd1:   return m_pipe[b];
      32'd2:   return ((m_cfg0 >> (8 + b)) & 32'd1) != 0 ? wmask(bw[b]) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] dut_out(int b);
    case (b)
      0:       return 32'(S1BEG);
      1:       return 32'(S2BEG);
      2:       return 32'(S2BEGb);
      default: return 32'(S4BEG);
    endcase
  endfunction

  task automatic model_reset();
    m_cfg0 = '0;
    m_cfg1 = '0;
    for (int b = 0; b < 4; b++) m_pipe[b] = '0;
    for (int k = 0; k < 5; k++) m_samp[k] = '0;
    m_primed = 0;
    m_flags  = '0;
  endtask

  task automatic model_edge();
    logic [4:0] set, clr;
    set = '0;
    for (int b = 0; b < 4; b++) m_pipe[b] = rot_ref(src_now(b), bw[b], rot_field(b));
    for (int k = 0; k < 5; k++) if (m_primed && src_now(k) != m_samp[k]) set[k] = 1'b1;
    clr     = FrameStrobe[2] ? FrameData[4:0] : 5'd0;
    m_flags = (m_flags & ~clr) | set;
    for (int k = 0; k < 5; k++) m_samp[k] = src_now(k);
    m_primed = 1;
    if (FrameStrobe[0]) m_cfg0 = FrameData;
    if (FrameStrobe[1]) m_cfg1 = FrameData;
  endtask

  task automatic check_all(input string tag);
    for (int b = 0; b < 4; b++)
      check($sformatf("%s_out%0d", tag, b), dut_out(b), exp_out(b));
    check($sformatf("%s_flags", tag), 32'(ActivityFlags), 32'(m_flags));
  endtask

  task automatic tick(input string tag);
    @(posedge UserCLK);
    model_edge();
    #1;
    FrameStrobe = '0;
    check_all(tag);
  endtask

  task automatic randomize_inputs();
    N1END = N1_W'($urandom);
    N2MID = N2_W'($urandom);
    N2END = N2_W'($urandom);
    N4END = N4_W'($urandom);
    Ci    = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    #1;
    check_all("in_rst");
    @(negedge UserCLK);
    resetn = 1'b1;
  endtask

  initial begin
    FrameData   = '0;
    FrameStrobe = '0;
    randomize_inputs();
    do_reset();

    // Reset defaults: direct, unrotated loopback
    N1END = 4'b1010;
    N4END = 16'h1234;
    #1;
    check("def_s1", 32'(S1BEG), 32'hA);
    check("def_s4", 32'(S4BEG), 32'h1234);
    check("def_flags", 32'(ActivityFlags), 32'h0);

    // Rotation
    FrameData = 32'd1; FrameStrobe = MF'(2);
    tick("rot0");
    N1END = 4'b0001;
    #1;
    check("rot_s1", 32'(S1BEG), 32'h8);
    FrameData = 32'd1 | (32'd9 << 5); FrameStrobe = MF'(2);
    tick("rot1");
    N2MID = 8'h01;
    #1;
    check("rot_s2", 32'(S2BEG), 32'h80);

    // Registered mode, then asynchronous reset mid-run
    FrameData = 32'd0; FrameStrobe = MF'(2);
    tick("rot_clr");
    N1END = 4'h0; FrameData = 32'd1; FrameStrobe = MF'(1);
    tick("reg_en");
    N1END = 4'hF;
    #1;
    check("reg_hold", 32'(S1BEG), 32'h0);
    tick("reg_cap");
    check("reg_upd", 32'(S1BEG), 32'hF);
    #2;
    resetn = 1'b0;
    model_reset();
    N1END = 4'h5;
    #1;
    check("reg_rst", 32'(S1BEG), 32'h5);
    check_all("reg_rst");
    @(negedge UserCLK);
    resetn = 1'b1;

    // Constant and zero modes
    FrameData = (32'd2 << 6) | (32'd1 << 11) | (32'd3 << 2); FrameStrobe = MF'(1);
    tick("cz");
    check("cz_s4", 32'(S4BEG), 32'hFFFF);
    check("cz_s2", 32'(S2BEG), 32'h0);
    randomize_inputs();
    #1;
    check("cz_s4_in", 32'(S4BEG), 32'hFFFF);
    check("cz_s2_in", 32'(S2BEG), 32'h0);
    check_all("cz_in");

    // Activity flags
    do_reset();
    tick("act_prime");
    tick("act_quiet");
    Ci = ~Ci;
    tick("act_ci");
    check("act_ci", 32'(ActivityFlags), 32'h10);
    Ci = ~Ci; FrameData = 32'h10; FrameStrobe = MF'(4);
    tick("act_setwins");
    check("act_setwins", 32'(ActivityFlags), 32'h10);
    FrameData = 32'h10; FrameStrobe = MF'(4);
    tick("act_clr");
    check("act_clr", 32'(ActivityFlags), 32'h0);

    // Strobe collisions and an ignored high frame
    FrameData = 32'h55; FrameStrobe = MF'(3);
    tick("coll");
    FrameData = $urandom; FrameStrobe = MF'(1) << 5;
    tick("f5");
    randomize_inputs();
    #1;
    check_all("f5_in");

    // Randomized run
    for (int it = 0; it < 400; it++) begin
      randomize_inputs();
      #1;
      check_all("rnd_comb");
      if ($urandom_range(0, 3) == 0) begin
        FrameData   = $urandom;
        FrameStrobe = MF'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 63) == 0) do_reset();
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/n_term_tile_cfg.md
# n_term_tile_cfg

Parameterised north-edge terminal tile for the fabric top row, the configurable successor to the fixed single-width terminator. It accepts the north-travelling wire bundles (N1END, N2MID, N2END, N4END, Ci) and loops them back as south-travelling bundles (S1BEG, S2BEG, S2BEGb, S4BEG). Per-bundle behaviour is set through the standard frame interface: direct, registered, or constant drive, plus a rotation of the loopback index. Sticky activity flags report which inbound bundles have toggled, for fabric bring-up.

## Interface
- N1_W, 4: width of the N1END and S1BEG bundles (1..32)
- N2_W, 8: width of N2MID, N2END, S2BEG and S2BEGb (1..32)
- N4_W, 16: width of the N4END and S4BEG bundles (1..32)
- FrameBitsPerRow, 32: FrameData width (≥20)
- MaxFramesPerCol, 20: FrameStrobe width (≥3)

- UserCLK  in  1  the single clock; all flops are rising-edge
- resetn  in  1  asynchronous, active-low reset
- FrameData  in  FrameBitsPerRow  configuration frame data
- FrameStrobe  in  MaxFramesPerCol  per-frame write strobe, sampled at the UserCLK rising edge
- N1END  in  N1_W  inbound single-hop wires
- N2MID  in  N2_W  inbound double-hop wires, mid taps
- N2END  in  N2_W  inbound double-hop wires, end taps
- N4END  in  N4_W  inbound quad-hop wires
- Ci  in  1  inbound carry
- S1BEG  out  N1_W  loopback of N1END
- S2BEG  out  N2_W  loopback of N2MID
- S2BEGb  out  N2_W  loopback of N2END
- S4BEG  out  N4_W  loopback of N4END
- ActivityFlags  out  5  sticky toggle flags in the order {Ci, N4END, N2END, N2MID, N1END}, bit 0 = N1END

## Operation

**Configuration registers**
- CFG0 is written when FrameStrobe[0]=1 at an edge; CFG1 is written when FrameStrobe[1]=1. Each takes the whole FrameData word.
- A strobe on frame 2 is not stored. Instead it clears the activity flags selected by FrameData[4:0].
- Strobes on frames ≥3 are ignored.
- If several strobes are high in the same edge, each one acts on the same FrameData.

**CFG0 fields**
- Bundle index b: 0=S1BEG, 1=S2BEG, 2=S2BEGb, 3=S4BEG.
- MODE_b = CFG0[2b+1:2b]:
  - 0: direct, combinational (the legacy behaviour)
  - 1: registered
  - 2: constant, every bit of the bundle = CONST_b
  - 3: all zeros
- CONST_b = CFG0[8+b].

**CFG1 fields**
- ROT_b = CFG1[5b+4:5b].
- The effective rotation is r = ROT_b mod W_b, where W_b is the bundle width.
- Loopback mapping: out[i] = src[(i + r) mod W_b].
- The modulo is a true modulo, so widths that are not powers of two are legal.

**Data path**
- Sources: S1BEG←N1END, S2BEG←N2MID, S2BEGb←N2END, S4BEG←N4END.
- The rotation is applied before the register stage.
- Each bundle's pipeline register captures its rotated source on every edge, whatever the mode.
- Ci only feeds the activity monitor; it does not drive any output.

**Activity monitor**
- Per-bundle sample registers and a `primed` bit.
- The first edge after reset only loads the samples and sets `primed`.
- On every later edge, flag k is set if any bit of source k differs from its previous sample.
- The sample registers update on every edge.
- If a set and a clear hit the same flag in the same edge, the set wins.

**Reset (resetn=0, asynchronous)**
- CFG0, CFG1, pipeline registers, samples, `primed` and ActivityFlags are all cleared to 0.
- While in reset, outputs equal the direct, unrotated loopback (S1BEG = N1END, etc.) and ActivityFlags = 0.
- A reset in the middle of a frame write discards that write.

## Timing
- Direct mode: zero-cycle combinational path, input to output.
- Registered mode: latency of 1 UserCLK. The output after edge n equals the rotated input sampled at edge n.
- A configuration write at edge n takes effect immediately after edge n.
- Switching a bundle to registered mode shows the value captured at edge n; there is no bubble and no stale reset value.
- Activity: a toggle seen between edges n-1 and n sets the flag after edge n.
- A frame-2 clear applied at edge n reads 0 after edge n, unless a toggle is detected at that same edge.
- Outputs in constant and zero modes change only on a configuration edge.

## Test plan
- Reset defaults: after resetn rises with no configuration, drive N1END=4'b1010, N4END=16'h1234 → S1BEG=4'b1010 and S4BEG=16'h1234 in the same cycle; ActivityFlags=0.
- Rotation: write CFG1=5'd1 on frame 1 (ROT_0=1) with N1END=4'b0001 → S1BEG=4'b1000. Then set ROT_1=9 with N2_W=8 (effective rotation 1) and N2MID=8'h01 → S2BEG=8'h80.
- Registered mode: write CFG0=2'b01 on frame 0 (MODE_0=1), then step N1END 0→F at edge k → S1BEG=0 until edge k+1, then F. A mid-run reset drops S1BEG to the combinational value immediately.
- Constant and zero modes: write CFG0 = (2<<6)|(1<<11)|(3<<2) → S4BEG=16'hFFFF and S2BEG=8'h00, both independent of the inputs.
- Activity: toggle Ci only → ActivityFlags=5'b10000 one edge later. Strobe frame 2 with FrameData=5'h10 while Ci toggles in the same cycle → the flag stays 1. Repeat without a toggle → 0.
- Strobe collisions: FrameStrobe=3'b011 with FrameData=32'h0000_0055 → CFG0 and CFG1 both hold 0x55. A strobe on frame 5 changes nothing.
